// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial pattern scanner (seq_scan_ctrl).
// Optional feature macro: SEQ_SCAN_OVERLAP_EN (count overlapping matches).
package seq_scan_pkg;

   localparam int PAT_W  = 4;
   localparam int VCNT_W = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : seq_scan_pkg

// File: rtl/seq_detect_core.sv
// Bit-serial PAT_W-bit sequence detector: history shift register, valid-bit count, compare.
// With SEQ_SCAN_OVERLAP_EN undefined the valid count restarts after each match.
module seq_detect_core
   import seq_scan_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             bit_en_i,
   input  logic             bit_i,
   input  logic [PAT_W-1:0] pattern_i,
   output logic             match_o
);

   localparam logic [VCNT_W-1:0] VCNT_FULL = VCNT_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [VCNT_W-1:0] vcnt_q, vcnt_d;

   // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      hist_d  = hist_q;
      vcnt_d  = vcnt_q;
      match_o = 1'b0;
      if (clear_i) begin
         hist_d = '0;
         vcnt_d = '0;
      end else if (bit_en_i) begin
         hist_d = {hist_q[PAT_W-2:0], bit_i};
         if (vcnt_q != VCNT_FULL) begin
            vcnt_d = vcnt_q + 1'b1;
         end
         match_o = (vcnt_d == VCNT_FULL) && (hist_d == pattern_i);
`ifdef SEQ_SCAN_OVERLAP_EN
         // History stays valid so the next bit can complete an overlapping match.
`else
         if (match_o) begin
            vcnt_d = '0;
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         vcnt_q <= '0;
      end else begin
         hist_q <= hist_d;
         vcnt_q <= vcnt_d;
      end
   end

endmodule : seq_detect_core

// File: rtl/seq_scan_ctrl.sv
// Word scanner: accepts a WORD_W-bit word, shifts it MSB first through a pattern detector,
// counts (saturating) matches and pulses done. Optional macro: SEQ_SCAN_OVERLAP_EN.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic [PAT_W-1:0]  pattern,
   output logic              busy,
   output logic              match_pulse,
   output logic              done,
   output logic [CNT_W-1:0]  match_count
);

   localparam int                    BIT_CNT_W = $clog2(WORD_W);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

   state_e                state_q, state_d;
   logic [WORD_W-1:0]     data_q, data_d;
   logic [PAT_W-1:0]      pat_q, pat_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  pulse_q, pulse_d;

   logic accept;
   logic bit_en;
   logic det_match;

   assign accept = (state_q == IDLE) && in_valid;
   assign bit_en = (state_q == SHIFT);

   seq_detect_core u_detect (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (accept),
      .bit_en_i  (bit_en),
      .bit_i     (data_q[WORD_W-1]),
      .pattern_i (pat_q),
      .match_o   (det_match)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      pat_d     = pat_q;
      bit_cnt_d = bit_cnt_q;
      count_d   = count_q;
      pulse_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d    = in_data;
               pat_d     = pattern;
               bit_cnt_d = '0;
               count_d   = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            data_d    = {data_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (det_match) begin
               pulse_d = 1'b1;
               if (count_q != CNT_MAX) begin
                  count_d = count_q + 1'b1;
               end
            end
            if (bit_cnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the word and pattern registers are reset too; they are small and this keeps X out of the compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         pat_q     <= '0;
         bit_cnt_q <= '0;
         count_q   <= '0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         pat_q     <= pat_d;
         bit_cnt_q <= bit_cnt_d;
         count_q   <= count_d;
         pulse_q   <= pulse_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q == SHIFT);
   assign done        = (state_q == DONE);
   assign match_pulse = pulse_q;
   assign match_count = count_q;

endmodule : seq_scan_ctrl

// File: tb/tb_seq_scan_ctrl.sv
// Directed, table-driven bench for seq_scan_ctrl (WORD_W=8); a CNT_W=2 copy checks saturation.
module tb_seq_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] pattern;

   logic       in_ready, busy, match_pulse, done;
   logic [3:0] match_count;
   logic       in_ready_s, busy_s, match_pulse_s, done_s;
   logic [1:0] match_count_s;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic [3:0] pat;
      logic [3:0] pat_mid;
      logic [7:0] data;
      logic [7:0] pulse_mask;   // bit j-1 set: pulse expected after bit j
      int         exp_cnt;
      int         exp_cnt_sat;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   seq_scan_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .pattern     (pattern),
      .busy        (busy),
      .match_pulse (match_pulse),
      .done        (done),
      .match_count (match_count)
   );

   seq_scan_ctrl #(.WORD_W(8), .CNT_W(2)) dut_sat (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready_s),
      .in_data     (in_data),
      .pattern     (pattern),
      .busy        (busy_s),
      .match_pulse (match_pulse_s),
      .done        (done_s),
      .match_count (match_count_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge with both DUTs in IDLE; returns in the IDLE cycle after DONE.
   task automatic run_word(input vec_t v);
      logic exp_pulse;
      check($sformatf("%s ready_before", v.name), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v.data;
      pattern  = v.pat;
      tick();
      in_valid = 1'b0;
      pattern  = v.pat_mid;
      in_data  = ~v.data;
      for (int c = 1; c <= 9; c++) begin
         exp_pulse = (c >= 2) ? v.pulse_mask[c-2] : 1'b0;
         check($sformatf("%s c%0d busy", v.name, c), 32'(busy), 32'(c <= 8));
         check($sformatf("%s c%0d ready", v.name, c), 32'(in_ready), 32'd0);
         check($sformatf("%s c%0d done", v.name, c), 32'(done), 32'(c == 9));
         check($sformatf("%s c%0d pulse", v.name, c), 32'(match_pulse), 32'(exp_pulse));
         if (c == 9) begin
            check($sformatf("%s count", v.name), 32'(match_count), 32'(v.exp_cnt));
            check($sformatf("%s count_sat", v.name), 32'(match_count_s), 32'(v.exp_cnt_sat));
            check($sformatf("%s done_sat", v.name), 32'(done_s), 32'd1);
         end
         tick();
      end
      check($sformatf("%s idle ready", v.name), 32'(in_ready), 32'd1);
      check($sformatf("%s idle done", v.name), 32'(done), 32'd0);
      check($sformatf("%s idle pulse", v.name), 32'(match_pulse), 32'd0);
      check($sformatf("%s count_hold", v.name), 32'(match_count), 32'(v.exp_cnt));
      tick();
      check($sformatf("%s count_hold2", v.name), 32'(match_count), 32'(v.exp_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"bb_1011", 4'b1011, 4'b1011, 8'b1011_1011, 8'b1000_1000, 2, 2};
`ifdef SEQ_SCAN_OVERLAP_EN
      vecs[1] = '{"aa_1010", 4'b1010, 4'b1010, 8'b1010_1010, 8'b1010_1000, 3, 3};
      vecs[2] = '{"00_0000", 4'b0000, 4'b0000, 8'h00,        8'b1111_1000, 5, 3};
      vecs[4] = '{"36_0110", 4'b0110, 4'b0110, 8'h36,        8'b1001_0000, 2, 2};
`else
      vecs[1] = '{"aa_1010", 4'b1010, 4'b1010, 8'b1010_1010, 8'b1000_1000, 2, 2};
      vecs[2] = '{"00_0000", 4'b0000, 4'b0000, 8'h00,        8'b1000_1000, 2, 2};
      vecs[4] = '{"36_0110", 4'b0110, 4'b0110, 8'h36,        8'b0001_0000, 1, 1};
`endif
      vecs[3] = '{"b0_patchg", 4'b1011, 4'b0000, 8'hB0,      8'b0000_1000, 1, 1};

      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      pattern  = '0;
      #2;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst pulse", 32'(match_pulse), 32'd0);
      check("rst count", 32'(match_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) run_word(vecs[i]);

      // in_valid held high: accepts every 10 cycles, ready low for the 9 in between.
      in_valid = 1'b1;
      in_data  = 8'b1011_1011;
      pattern  = 4'b1011;
      for (int c = 0; c <= 20; c++) begin
         check($sformatf("stream c%0d ready", c), 32'(in_ready), 32'((c % 10) == 0));
         check($sformatf("stream c%0d done", c), 32'(done), 32'((c % 10) == 9));
         if ((c % 10) == 9) check($sformatf("stream c%0d count", c), 32'(match_count), 32'd2);
         tick();
      end
      in_valid = 1'b0;
      repeat (9) tick();
      check("stream back_idle", 32'(in_ready), 32'd1);

      // Reset in the 4th SHIFT cycle aborts the word.
      in_valid = 1'b1;
      in_data  = 8'b1010_1010;
      pattern  = 4'b1010;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("abort busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort pulse", 32'(match_pulse), 32'd0);
      check("abort count", 32'(match_count), 32'd0);
      check("abort count_sat", 32'(match_count_s), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int c = 0; c < 10; c++) begin
         check($sformatf("abort c%0d no_done", c), 32'(done), 32'd0);
         check($sformatf("abort c%0d idle", c), 32'(in_ready), 32'd1);
         tick();
      end
      run_word(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_scan_ctrl

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, which is the input word width in bits (legal 4..32).
REQ-002 SHALL have parameter CNT_W, default 4, which is the match counter width in bits (legal 1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port in_valid, input, 1 bit: a word is offered on in_data.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, WORD_W bits: the word to scan, shifted MSB first.
REQ-008 SHALL have port pattern, input, 4 bits: the sequence to detect, first bit = pattern[3].
REQ-009 SHALL have port busy, output, 1 bit: a word is being scanned.
REQ-010 SHALL have port match_pulse, output, 1 bit: one-cycle pulse per detected match.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a word; match_count is final.
REQ-012 SHALL have port match_count, output, CNT_W bits: the number of matches in the current or last word.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE; in_ready = (state==IDLE); busy = (state==SHIFT).
REQ-014 SHALL, in IDLE with in_valid=1, accept on that edge: latch in_data and pattern, clear match_count, clear detector history, and go to SHIFT.
REQ-015 SHALL stay in SHIFT for exactly WORD_W cycles, consuming one bit per edge, MSB first; after the last bit it goes to DONE.
REQ-016 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE; accepted words are spaced at least WORD_W+2 cycles apart.
REQ-017 SHALL declare a match on the edge that consumes a bit when the last 4 consumed bits equal the latched pattern and at least 4 bits are valid in the history.
REQ-018 SHALL register match_pulse: it is high in the cycle after the matching edge, so the last-bit match pulse coincides with done.
REQ-019 SHALL increment match_count on each match and saturate at 2^CNT_W-1, with no wrap.
REQ-020 SHALL hold match_count stable from DONE until the next accept.
REQ-021 SHALL ignore changes to pattern or in_data outside the accept edge.
REQ-022 SHALL ignore in_valid while busy or in DONE; no word is lost, because in_ready=0 in those states.

Reset
REQ-023 SHALL, when reset=0, asynchronously force state=IDLE, match_count=0, match_pulse=0, done=0, busy=0 and history cleared; in_ready=1.
REQ-024 SHALL treat reset asserted mid-SHIFT as aborting the word: no done pulse is generated, and the first accept is allowed on the first edge after release.

Configuration
REQ-025 SHALL, when macro SEQ_SCAN_OVERLAP_EN is defined, count overlapping matches: history is retained after a match.
REQ-026 SHALL, when SEQ_SCAN_OVERLAP_EN is undefined, count non-overlapping matches only: the history valid count is cleared on a match, so the next match needs 4 fresh bits.

Structure
REQ-027 SHALL place the state enum (IDLE/SHIFT/DONE) and the constant PAT_W=4 in the shared package seq_scan_pkg.
REQ-028 SHALL instantiate one sub-module, seq_detect_core, containing the 4-bit history shift register, the valid-bit counter and the pattern compare; it has a clear input and a bit-enable input.

Verification (WORD_W=8)
REQ-029 SHALL cover: pattern 1011, data 8'b1011_1011, either config -> match_count=2, match_pulse high in the cycles after bits 4 and 8, done 9 cycles after accept.
REQ-030 SHALL cover: pattern 1010, data 8'b1010_1010 -> count=3 with SEQ_SCAN_OVERLAP_EN and count=2 without it.
REQ-031 SHALL cover: CNT_W=2, pattern 0000, data 8'h00 with overlap -> 5 pulses and count saturated at 3; without overlap -> count=2.
REQ-032 SHALL cover: in_valid held high continuously -> in_ready low for 9 cycles after each accept, and accepts exactly 10 cycles apart.
REQ-033 SHALL cover: reset pulsed low at the 4th SHIFT cycle -> all outputs 0 immediately, in_ready=1, no done pulse, and a fresh word scanned correctly afterwards.
REQ-034 SHALL cover: pattern changed during SHIFT from 1011 to 0000 with data 8'hB0 -> count reflects 1011 only (=1).
